// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between N requesters.
// Each granted access holds its strobe for WAIT+1 cycles, then pulses done for one cycle.
module mem_arbiter #(
    parameter int N    = 3,
    parameter int AW   = 20,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    wr,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_a,
    output logic [DW-1:0]   mem_wd,
    output logic            mem_re,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_rd
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   win;
    logic            found;
    logic [3:0]      cnt, cnt_n;
    logic [N-1:0]    gnt_n, done_n;
    logic [DW-1:0]   rdata_n, mem_wd_n;
    logic [AW-1:0]   mem_a_n;
    logic            mem_re_n, mem_we_n;

    // First requesting index at or after ptr, wrapping mod N.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        gnt_n    = gnt;
        done_n   = done;
        rdata_n  = rdata;
        mem_a_n  = mem_a;
        mem_wd_n = mem_wd;
        mem_re_n = mem_re;
        mem_we_n = mem_we;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_n      = '0;
                    gnt_n[win] = 1'b1;
                    mem_a_n    = addr[int'(win)*AW +: AW];
                    mem_wd_n   = wdata[int'(win)*DW +: DW];
                    mem_re_n   = !wr[win];
                    mem_we_n   = wr[win];
                    cnt_n      = 4'(WAIT);
                    ptr_n      = (int'(win) == N - 1) ? '0 : win + 1'b1;
                    state_n    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // The strobe itself still encodes the latched direction.
                    if (mem_re) rdata_n = mem_rd;
                    mem_re_n = 1'b0;
                    mem_we_n = 1'b0;
                    done_n   = gnt;
                    state_n  = DONE;
                end
            end
            DONE: begin
                done_n  = '0;
                gnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            rdata  <= '0;
            mem_a  <= '0;
            mem_wd <= '0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            gnt    <= gnt_n;
            done   <= done_n;
            rdata  <= rdata_n;
            mem_a  <= mem_a_n;
            mem_wd <= mem_wd_n;
            mem_re <= mem_re_n;
            mem_we <= mem_we_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions against a
// transaction-level round-robin and memory model.
module tb_mem_arbiter;

    localparam int N    = 3;
    localparam int AW   = 20;
    localparam int DW   = 8;
    localparam int WAIT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata, mem_wd, mem_rd;
    logic [AW-1:0]   mem_a;
    logic            mem_re, mem_we;

    int checks = 0;
    int errors = 0;
    int mptr;
    logic [DW-1:0] exp_rdata;
    logic [7:0]    ref_mem [64];
    logic [7:0]    ram [64];
    logic          ram_inited = 1'b0;
    logic          rd_ovr_en  = 1'b0;
    logic [7:0]    rd_ovr     = 8'h00;

    mem_arbiter #(.N(N), .AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Simple 64-byte RAM aliased on the low address bits.
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'(i * 7 + 3);
            ram_inited <= 1'b1;
        end else if (mem_we) begin
            ram[mem_a[5:0]] <= mem_wd;
        end
    end
    assign mem_rd = rd_ovr_en ? rd_ovr : ram[mem_a[5:0]];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (!$onehot0(gnt) || !$onehot0(done) || ((done & ~gnt) != 0) || (mem_re && mem_we)) begin
                errors++;
                $display("FAIL invariant: gnt=%b done=%b re=%b we=%b", gnt, done, mem_re, mem_we);
            end
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        tick; tick;
        rst = 1'b0;
        mptr = 0;
        exp_rdata = '0;
    endtask

    task automatic drain;
        req = '0;
        for (int c = 0; c < 20 && (gnt != 0 || done != 0); c++) tick;
        tick;
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL drain: gnt=%b required 0", gnt); end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '1; wr = 3'b010; addr = '1; wdata = '1;
        tick; tick;
        checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL reset_gnt_done: gnt=%b done=%b required 0", gnt, done); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: re=%b we=%b required 0", mem_re, mem_we); end
        checks++; if (mem_a !== '0 || mem_wd !== '0 || rdata !== '0) begin errors++; $display("FAIL reset_data: a=%h wd=%h rd=%h required 0", mem_a, mem_wd, rdata); end
        req = '0; rst = 1'b0; mptr = 0;
        tick;
    endtask

    task automatic test_single_read;
        do_reset;
        rd_ovr_en = 1'b1; rd_ovr = 8'hA5;
        set_slot(0, 1'b0, 20'h12345, 8'h00);
        req = 3'b001;
        tick;
        checks++; if (gnt !== 3'b001 || done !== '0) begin errors++; $display("FAIL read_grant: gnt=%b done=%b required 001/000", gnt, done); end
        checks++; if ({mem_re, mem_we, mem_a} !== {1'b1, 1'b0, 20'h12345}) begin errors++; $display("FAIL read_strobe: re=%b we=%b a=%h required 1/0/12345", mem_re, mem_we, mem_a); end
        for (int k = 0; k < WAIT; k++) begin
            tick;
            checks++; if ({mem_re, mem_a, done} !== {1'b1, 20'h12345, 3'b000}) begin errors++; $display("FAIL read_hold: re=%b a=%h done=%b", mem_re, mem_a, done); end
        end
        tick;
        checks++; if (done !== 3'b001 || gnt !== 3'b001) begin errors++; $display("FAIL read_done: done=%b gnt=%b required 001", done, gnt); end
        checks++; if (rdata !== 8'hA5 || mem_re !== 1'b0) begin errors++; $display("FAIL read_data: rdata=%h re=%b required a5/0", rdata, mem_re); end
        req = '0;
        tick;
        checks++; if (done !== '0 || gnt !== '0) begin errors++; $display("FAIL read_idle: done=%b gnt=%b required 0", done, gnt); end
        rd_ovr_en = 1'b0;
        mptr = 1;
    endtask

    task automatic test_single_write;
        set_slot(1, 1'b1, 20'h00FF0, 8'h3C);
        req = 3'b010;
        tick;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL write_grant: gnt=%b required 010", gnt); end
        for (int k = 0; k <= WAIT; k++) begin
            if (k > 0) tick;
            checks++; if ({mem_we, mem_re, mem_wd, mem_a} !== {1'b1, 1'b0, 8'h3C, 20'h00FF0}) begin errors++; $display("FAIL write_strobe: we=%b re=%b wd=%h a=%h", mem_we, mem_re, mem_wd, mem_a); end
        end
        tick;
        checks++; if (done !== 3'b010 || mem_we !== 1'b0) begin errors++; $display("FAIL write_done: done=%b we=%b required 010/0", done, mem_we); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL write_rdata_kept: rdata=%h required a5", rdata); end
        ref_mem[6'h30] = 8'h3C;
        req = '0;
        tick;
        mptr = 2;
    endtask

    task automatic test_round_robin;
        int ng, last_c, dbl, e;
        logic [N-1:0] pg, pd, eg;
        do_reset;
        for (int i = 0; i < N; i++) set_slot(i, 1'b0, AW'(i * 16 + 5), 8'h00);
        req = '1; pg = '0; pd = '0; ng = 0; last_c = 0; dbl = 0;
        for (int c = 1; c <= 60 && ng < 4; c++) begin
            tick;
            if (done != 0 && pd != 0) dbl++;
            if (pg == 0 && gnt != 0) begin
                e = rr_pick(req, mptr);
                eg = N'(1) << e;
                checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_order: grant %0d gnt=%b required %b", ng, gnt, eg); end
                checks++; if ((ng == 0 && c != 1) || (ng > 0 && c - last_c != WAIT + 3)) begin errors++; $display("FAIL rr_spacing: grant %0d at cycle %0d, previous %0d", ng, c, last_c); end
                last_c = c; mptr = (e + 1) % N; ng++;
            end
            pg = gnt; pd = done;
        end
        checks++; if (ng != 4) begin errors++; $display("FAIL rr_count: %0d grants seen required 4", ng); end
        req = '0;
        for (int c = 0; c < 20 && (gnt != 0 || done != 0); c++) begin
            tick;
            if (done != 0 && pd != 0) dbl++;
            pd = done;
        end
        checks++; if (dbl != 0) begin errors++; $display("FAIL rr_done_pulse: %0d multi-cycle done pulses required 0", dbl); end
    endtask

    task automatic test_starvation;
        int ng, g2, e;
        logic [N-1:0] pg, eg;
        do_reset;
        for (int i = 0; i < N; i++) set_slot(i, 1'b0, AW'(i * 3 + 1), 8'h00);
        req = 3'b001;
        tick;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL starve_first: gnt=%b required 001", gnt); end
        mptr = 1;
        req[2] = 1'b1; pg = gnt; ng = 0; g2 = 0;
        for (int c = 0; c < 80 && ng < 3; c++) begin
            tick;
            if (pg == 0 && gnt != 0) begin
                ng++;
                e = rr_pick(req, mptr);
                eg = N'(1) << e;
                checks++; if (gnt !== eg) begin errors++; $display("FAIL starve_order: gnt=%b required %b", gnt, eg); end
                mptr = (e + 1) % N;
                if (gnt[2] && g2 == 0) g2 = ng;
            end
            if (done[2]) req[2] = 1'b0;
            pg = gnt;
        end
        checks++; if (g2 < 1 || g2 > 2) begin errors++; $display("FAIL starve_req2: granted at grant %0d required 1..2", g2); end
        drain;
    endtask

    task automatic test_mid_reset;
        do_reset;
        set_slot(0, 1'b1, 20'h0ABC7, 8'h5A);
        req = 3'b001;
        tick;
        checks++; if (mem_we !== 1'b1 || gnt !== 3'b001) begin errors++; $display("FAIL midrst_start: we=%b gnt=%b required 1/001", mem_we, gnt); end
        tick;
        rst = 1'b1;
        tick;
        checks++; if (mem_we !== 1'b0 || gnt !== '0 || done !== '0) begin errors++; $display("FAIL midrst_abort: we=%b gnt=%b done=%b required 0", mem_we, gnt, done); end
        ref_mem[6'h07] = 8'h5A;
        rst = 1'b0; mptr = 0;
        set_slot(2, 1'b0, 20'h00002, 8'h00);
        req = 3'b100;
        tick;
        checks++; if (gnt !== (N'(1) << rr_pick(3'b100, mptr))) begin errors++; $display("FAIL midrst_regrant: gnt=%b required 100", gnt); end
        drain;
    endtask

    task automatic test_input_change;
        logic [7:0] er;
        do_reset;
        set_slot(0, 1'b0, 20'hABCDE, 8'h00);
        er = ref_mem[6'h1E];
        req = 3'b001;
        tick;
        checks++; if (gnt !== 3'b001 || mem_a !== 20'hABCDE) begin errors++; $display("FAIL chg_grant: gnt=%b a=%h required 001/abcde", gnt, mem_a); end
        set_slot(0, 1'b1, 20'h11111, 8'hFF);
        req = '0;
        for (int k = 0; k < WAIT; k++) begin
            tick;
            checks++; if ({mem_a, mem_re, mem_we} !== {20'hABCDE, 1'b1, 1'b0}) begin errors++; $display("FAIL chg_hold: a=%h re=%b we=%b", mem_a, mem_re, mem_we); end
        end
        tick;
        checks++; if (done !== 3'b001 || rdata !== er) begin errors++; $display("FAIL chg_done: done=%b rdata=%h required 001/%h", done, rdata, er); end
        tick;
        checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL chg_idle: gnt=%b done=%b required 0", gnt, done); end
    endtask

    task automatic test_random;
        logic [N-1:0] r, eg;
        int w;
        logic ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        do_reset;
        for (int t = 0; t < 200; t++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_slot(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            req = r;
            if (r == 0) begin
                tick;
                checks++; if (gnt !== '0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rnd_idle: gnt=%b re=%b we=%b required 0", gnt, mem_re, mem_we); end
                continue;
            end
            w = rr_pick(r, mptr);
            ew = wr[w]; ea = addr[w*AW +: AW]; ed = wdata[w*DW +: DW];
            eg = N'(1) << w;
            tick;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_grant: t=%0d gnt=%b required %b", t, gnt, eg); end
            checks++; if ({mem_a, mem_wd, mem_re, mem_we} !== {ea, ed, !ew, ew}) begin errors++; $display("FAIL rnd_bus: t=%0d a=%h wd=%h re=%b we=%b required %h %h %b %b", t, mem_a, mem_wd, mem_re, mem_we, ea, ed, !ew, ew); end
            mptr = (w + 1) % N;
            for (int i = 0; i < N; i++) set_slot(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            req = N'($urandom_range(0, (1 << N) - 1));
            for (int k = 0; k < WAIT; k++) begin
                tick;
                checks++; if ({mem_a, mem_re, mem_we, done} !== {ea, !ew, ew, N'(0)}) begin errors++; $display("FAIL rnd_hold: t=%0d a=%h re=%b we=%b done=%b", t, mem_a, mem_re, mem_we, done); end
            end
            tick;
            if (ew) ref_mem[ea[5:0]] = ed;
            else exp_rdata = ref_mem[ea[5:0]];
            checks++; if (done !== eg || gnt !== eg) begin errors++; $display("FAIL rnd_done: t=%0d done=%b gnt=%b required %b", t, done, gnt, eg); end
            checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata: t=%0d rdata=%h required %h", t, rdata, exp_rdata); end
            checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rnd_strobe_off: t=%0d re=%b we=%b required 0", t, mem_re, mem_we); end
            tick;
            checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL rnd_release: t=%0d gnt=%b done=%b required 0", t, gnt, done); end
        end
        drain;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        test_reset;
        test_single_read;
        test_single_write;
        test_round_robin;
        test_starvation;
        test_mid_reset;
        test_input_change;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 20-bit-address, 8-bit-data RAM port between up to N requesters, e.g. instruction fetch, operand load and store.
- Round-robin arbitration with a req/gnt/done handshake; each access has a parameterised number of wait states.
- Sequences the RAM strobes (re/we) and drives address and write data to the memory. Requesters never drive the memory bus directly.

Parameters:
- N, 3, number of requesters (2..8); index 0 is the highest priority after reset.
- AW, 20, address width.
- DW, 8, data width.
- WAIT, 1, extra access cycles beyond the first (0..15); strobes are held for WAIT+1 cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester access request; level, held until done.
- wr  input  N  per-requester direction; 1 = write, 0 = read. Sampled at grant.
- addr  input  N*AW  per-requester address; slice i = bits [i*AW +: AW]. Sampled at grant.
- wdata  input  N*DW  per-requester write data; slice i = bits [i*DW +: DW]. Sampled at grant.
- gnt  output  N  one-hot grant; high from the grant edge through the done cycle.
- done  output  N  one-cycle completion pulse for the granted requester.
- rdata  output  DW  read data; valid in the done cycle and held until the next read completes.
- mem_a  output  AW  RAM address.
- mem_wd  output  DW  RAM write data.
- mem_re  output  1  RAM read strobe.
- mem_we  output  1  RAM write strobe.
- mem_rd  input  DW  RAM read data; sampled on the last access cycle.

Behaviour:
- States: IDLE, ACCESS, DONE. All outputs are registered.
- Reset: state=IDLE, ptr=0, gnt=0, done=0, rdata=0, mem_a=0, mem_wd=0, mem_re=0, mem_we=0, wait counter=0. Reset has priority over everything.
- IDLE: if any req bit is set at edge E:
  - Winner = first set bit searching from ptr upward, wrapping mod N.
  - gnt<=onehot(winner); mem_a, mem_wd and direction latched from the winner's slices.
  - mem_re<=!wr[winner], mem_we<=wr[winner]; cnt<=WAIT; ptr<=(winner+1) mod N; state<=ACCESS.
  - If no req bit is set, stay in IDLE and change nothing.
- ACCESS: strobes, mem_a and mem_wd are stable for exactly WAIT+1 cycles (cycles E..E+WAIT).
  - While cnt!=0: cnt<=cnt-1.
  - When cnt==0:
    - mem_re<=0, mem_we<=0.
    - For a read, rdata<=mem_rd. A write leaves rdata unchanged.
    - done[winner]<=1, state<=DONE.
- DONE: lasts one cycle (E+WAIT+1).
  - gnt still asserted.
  - At the next edge: done<=0, gnt<=0, state<=IDLE.
- Timing:
  - Earliest next grant is edge E+WAIT+3, so one access takes WAIT+3 cycles.
  - The arbiter is not pipelined; back-to-back requests from different requesters alternate in round-robin order.
- Input changes:
  - addr, wdata and wr changes after the grant are ignored.
  - Dropping req during ACCESS does not abort the access; done still pulses.
  - A requester that holds req high through DONE is re-arbitrated in IDLE like any other requester. It gets no repeat priority because ptr has already moved past it.
- Invariants:
  - gnt and done are one-hot or zero.
  - done implies the matching gnt bit is set.
  - mem_re and mem_we are never both 1.
  - mem_re and mem_we are 0 in IDLE and DONE.
- Reset mid-access: at the reset edge all strobes, gnt and done drop to 0 and the access is abandoned. ptr returns to 0.
- WAIT=0: a single-cycle strobe; done pulses at edge E+1.

Test Plan:
- Single read (N=3, WAIT=1): req=001, addr0=0x12345, mem_rd=0xA5 -> gnt=001 at E; mem_re=1 and mem_a=0x12345 in cycles E and E+1; done=001 and rdata=0xA5 at E+2; IDLE at E+3.
- Single write: req=010, wr=010, addr1=0x00FF0, wdata1=0x3C -> mem_we=1 and mem_wd=0x3C for 2 cycles; mem_re=0 throughout; done=010; rdata keeps its previous value.
- Round-robin: req=111 held from reset -> grant order 0,1,2,0; grants 4 cycles apart; each done is a single pulse.
- Starvation check: req0 held permanently and req2 asserted once -> req2 is granted no later than the second grant after its assertion.
- Mid-access reset: assert rst in cycle E+1 of a write -> mem_we=0, gnt=0, done=0 next cycle; after release, req=100 is granted with ptr=0 order (bit 2 wins only because bits 0 and 1 are clear).
- Input changes after grant: change addr0 and drop req0 at cycle E+1 -> mem_a keeps the latched value, done=001 still pulses at E+2; WAIT=0 build shows done at E+1.
